crypto_pipe_sched: RTL and testbench
====================================

// Module: crypto_pipe_sched
// PURPOSE
//   Multi-requester scheduler for the 3-stage crypto pipeline (shift-add / FSM / cleanup).
//   Round-robin arbitrates NUM_REQ clients and issues one 16-bit word per cycle with its 6-bit key.
//   Drains the pipeline before any key change, because stage 3 consumes live FSM state.
//   Tracks in-flight tags and returns each result to its originating client.
// PARAMETERS
//   NUM_REQ   4   number of requesting clients (2..8)
//   PIPE_LAT  4   cycles from pipe_valid to matching result on pipe_res_data
//   ID_W      2   width of rsp_id; must satisfy 2**ID_W >= NUM_REQ
// PORTS
//   clk           in   1            single clock for the whole block
//   rst           in   1            asynchronous, active-high reset
//   req_valid     in   NUM_REQ      per-client request valid
//   req_ready     out  NUM_REQ      per-client accept (one-hot or zero)
//   req_data      in   NUM_REQ*16   client i word at [16*i +: 16]
//   req_key       in   NUM_REQ*6    client i key at [6*i +: 6]
//   pipe_valid    out  1            issue strobe into the pipeline
//   pipe_data     out  16           word to pipeline stage 1
//   pipe_key      out  6            key to pipeline; held stable between issues
//   pipe_res_data in   16           pipeline stage 3 output
//   rsp_valid     out  1            result strobe, one cycle
//   rsp_id        out  ID_W         client index of the result
//   rsp_data      out  16           result word
//   busy          out  1            high when any word is in flight or state != IDLE
// BEHAVIOUR
//   Reset: all outputs 0, cur_key=0, rr pointer=0, tag shift register cleared, state=IDLE.
//   Reset mid-operation discards all in-flight tags; no rsp_valid for them, ever.
//   Handshake: transfer on req_valid[i] & req_ready[i]. req_ready may depend on req_valid;
//     clients must not make req_valid depend on req_ready. Once raised, valid holds until accepted.
//   Arbitration: round-robin starting at pointer; after a grant to i, pointer = (i+1) mod NUM_REQ.
//     The pointer is unchanged when no grant occurs.
//   FSM states:
//     IDLE  : no valid requests; on any valid, evaluate the winner in the same cycle.
//     ISSUE : winner key == cur_key, or inflight==0 -> grant. req_ready[w]=1 combinationally;
//             next edge registers pipe_valid=1, pipe_data, pipe_key=key_w (cur_key<=key_w).
//             Winner key != cur_key with inflight != 0 -> no grant; go to DRAIN and latch the
//             winner index (winner frozen, pointer frozen).
//     DRAIN : req_ready=0; stay until inflight==0; then return to ISSUE. The latched winner is
//             granted first with its new key.
//   Issue latency: one cycle from handshake to pipe_valid. Max 1 issue/cycle; back-to-back allowed.
//   Tag tracking: shift register, PIPE_LAT deep, of {valid, id}, advanced every cycle.
//     The entry loaded at issue exits after PIPE_LAT cycles; on exit with valid=1:
//     register rsp_valid=1, rsp_id=id, rsp_data=pipe_res_data (1 cycle later).
//   inflight = count of valid tag entries (0..PIPE_LAT); the issue and exit of the same
//     cycle net to 0.
//   Responses are not back-pressured; the pipeline cannot stall.
//   pipe_key never changes while inflight != 0.
//   pipe_data holds its last value while pipe_valid=0.
//   NUM_REQ=1 degenerates to a pass-through with key-drain.
// STRUCTURE
//   Shared package crypto_pkg: DATA_W=16, KEY_W=6, sched_state_t {IDLE, ISSUE, DRAIN}.
//   Sub-module crypto_rr_arbiter (NUM_REQ): inputs req and pointer; outputs one-hot gnt and
//     winner index. Purely combinational; the pointer register stays in crypto_pipe_sched.
//   Tag shift register and inflight counter are inline.
// TESTING
//   1 Single client 0 sends 0x1234 with key 6'h2A -> pipe_valid 1 cycle later, pipe_key=2A;
//     rsp_valid PIPE_LAT+1 cycles after pipe_valid, rsp_id=0, rsp_data=pipe_res_data.
//   2 All 4 clients valid, same key 6'h05, pointer 0 -> grants in order 0,1,2,3 on consecutive
//     cycles; responses return in order 0,1,2,3 with no gaps.
//   3 Client 1 key 6'h05 issued; client 2 immediately requests key 6'h11 -> DRAIN for PIPE_LAT
//     cycles with req_ready=0; client 2 issued when inflight==0; pipe_key changes only then.
//   4 Client 3 held valid while clients 0-2 saturate -> client 3 is granted within NUM_REQ cycles
//     (no starvation).
//   5 Assert rst 2 cycles after 3 issues -> all outputs 0 immediately; no rsp_valid for those
//     issues after reset release; busy=0.
//   6 No requests for 20 cycles after traffic -> busy=0, pipe_valid=0, pipe_key retains last key.

Source files
------------

// File: rtl/crypto_pkg.sv
// Shared definitions for the crypto pipeline scheduler: datapath widths,
// scheduler state encoding and the round-robin pointer advance helper.
package crypto_pkg;

  localparam int DATA_W = 16;
  localparam int KEY_W  = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

  // Index of the client that follows idx in a ring of n clients.
  function automatic int rr_next(input int idx, input int n);
    return ((idx + 1) >= n) ? 0 : (idx + 1);
  endfunction

endpackage

// File: rtl/crypto_rr_arbiter.sv
// Combinational round-robin arbiter: scans the request vector starting at
// the pointer position and returns the first requester as a one-hot grant
// plus its index. The pointer register itself lives in the scheduler.
module crypto_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    winner,
  output logic               any
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [ID_W:0] pos_s;
  logic          hit_s;

  // Walk the ring from ptr; the first set request wins.
  always_comb begin
    gnt    = '0;
    winner = '0;
    any    = 1'b0;
    pos_s  = '0;
    hit_s  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos_s  = {1'b0, ptr} + (ID_W+1)'(k);
      pos_s  = (pos_s >= (ID_W+1)'(NUM_REQ)) ? (pos_s - (ID_W+1)'(NUM_REQ)) : pos_s;
      hit_s  = ~any & req[pos_s[IDX_W-1:0]];
      gnt[pos_s[IDX_W-1:0]] = gnt[pos_s[IDX_W-1:0]] | hit_s;
      winner = hit_s ? pos_s[ID_W-1:0] : winner;
      any    = any | hit_s;
    end
  end

endmodule

// File: rtl/crypto_pipe_sched.sv
// Multi-client scheduler for the 3-stage crypto pipeline. Arbitrates clients
// round-robin, issues one word per cycle, drains the pipeline before any key
// change (stage 3 consumes live FSM state), and routes each result back to
// the client that issued it using a tag shift register.
module crypto_pipe_sched
  import crypto_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int PIPE_LAT = 4,
  parameter int ID_W     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*KEY_W-1:0]  req_key,
  output logic                      pipe_valid,
  output logic [DATA_W-1:0]         pipe_data,
  output logic [KEY_W-1:0]          pipe_key,
  input  logic [DATA_W-1:0]         pipe_res_data,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy
);

  localparam int CNT_W = $clog2(PIPE_LAT + 1);

  sched_state_t         state_r, state_nxt_s;
  logic [ID_W-1:0]      rr_ptr_r;
  logic                 pend_r;
  logic [ID_W-1:0]      pend_id_r;

  logic [NUM_REQ-1:0]   arb_gnt_s;
  logic [ID_W-1:0]      arb_win_s;
  logic                 arb_any_s;

  logic [NUM_REQ-1:0]   pend_oh_s;
  logic                 pend_ok_s;
  logic [NUM_REQ-1:0]   win_oh_s;
  logic [ID_W-1:0]      win_idx_s;
  logic                 win_any_s;
  logic [DATA_W-1:0]    win_data_s;
  logic [KEY_W-1:0]     win_key_s;

  logic                 grant_s;
  logic                 drain_go_s;

  logic [PIPE_LAT-1:0]  tag_vld_r;
  logic [ID_W-1:0]      tag_id_r [PIPE_LAT];
  logic                 exit_vld_r;
  logic [ID_W-1:0]      exit_id_r;
  logic [CNT_W-1:0]     inflight_r, inflight_nxt_s;

  crypto_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr_r),
    .gnt    (arb_gnt_s),
    .winner (arb_win_s),
    .any    (arb_any_s)
  );

  // Decode the client latched during a drain into a one-hot vector.
  always_comb begin
    pend_oh_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pend_oh_s[i] = (ID_W'(i) == pend_id_r);
    end
  end

  // Pick the winner: a latched drain winner has priority over the arbiter,
  // then mux out its word and key with an AND-OR select.
  always_comb begin
    pend_ok_s  = pend_r & (|(pend_oh_s & req_valid));
    win_oh_s   = pend_ok_s ? pend_oh_s : arb_gnt_s;
    win_idx_s  = pend_ok_s ? pend_id_r : arb_win_s;
    win_any_s  = pend_ok_s | arb_any_s;
    win_data_s = '0;
    win_key_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_data_s = win_data_s | ({DATA_W{win_oh_s[i]}} & req_data[DATA_W*i +: DATA_W]);
      win_key_s  = win_key_s  | ({KEY_W{win_oh_s[i]}}  & req_key[KEY_W*i +: KEY_W]);
    end
  end

  // Scheduler FSM: grant when the key matches or the pipe is empty, else drain.
  always_comb begin
    state_nxt_s = state_r;
    grant_s     = 1'b0;
    drain_go_s  = 1'b0;
    case (state_r)
      IDLE, ISSUE: begin
        if (win_any_s) begin
          if ((win_key_s == pipe_key) || (inflight_r == '0)) begin
            grant_s     = 1'b1;
            state_nxt_s = ISSUE;
          end else begin
            drain_go_s  = 1'b1;
            state_nxt_s = DRAIN;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DRAIN: begin
        if (inflight_r == '0) begin
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Ready is combinational so the handshake and the issue happen in one cycle;
  // it is forced low while reset is asserted.
  assign req_ready = (grant_s & ~rst) ? win_oh_s : '0;

  // In-flight count: an issue and an exit in the same cycle cancel out.
  always_comb begin
    case ({grant_s, tag_vld_r[PIPE_LAT-1]})
      2'b10:   inflight_nxt_s = inflight_r + CNT_W'(1);
      2'b01:   inflight_nxt_s = inflight_r - CNT_W'(1);
      default: inflight_nxt_s = inflight_r;
    endcase
  end

  assign busy = (inflight_r != '0) || (state_r != IDLE);

  // FSM state, round-robin pointer and latched drain winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      rr_ptr_r  <= '0;
      pend_r    <= 1'b0;
      pend_id_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (grant_s) begin
        rr_ptr_r <= ID_W'(rr_next(int'(win_idx_s), NUM_REQ));
      end
      if (grant_s) begin
        pend_r <= 1'b0;
      end else if (drain_go_s) begin
        pend_r    <= 1'b1;
        pend_id_r <= win_idx_s;
      end else if (!pend_ok_s) begin
        pend_r <= 1'b0;
      end
    end
  end

  // Issue register; the key register doubles as the current pipeline key.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_valid <= 1'b0;
      pipe_data  <= '0;
      pipe_key   <= '0;
    end else begin
      pipe_valid <= grant_s;
      if (grant_s) begin
        pipe_data <= win_data_s;
        pipe_key  <= win_key_s;
      end
    end
  end

  // Tag shift register tracking which client owns each word in the pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld_r  <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        tag_id_r[i] <= '0;
      end
      exit_vld_r <= 1'b0;
      exit_id_r  <= '0;
      inflight_r <= '0;
    end else begin
      tag_vld_r[0] <= grant_s;
      tag_id_r[0]  <= grant_s ? win_idx_s : '0;
      for (int i = 1; i < PIPE_LAT; i++) begin
        tag_vld_r[i] <= tag_vld_r[i-1];
        tag_id_r[i]  <= tag_id_r[i-1];
      end
      exit_vld_r <= tag_vld_r[PIPE_LAT-1];
      exit_id_r  <= tag_id_r[PIPE_LAT-1];
      inflight_r <= inflight_nxt_s;
    end
  end

  // Response register: capture the stage-3 word alongside its exiting tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= exit_vld_r;
      if (exit_vld_r) begin
        rsp_id   <= exit_id_r;
        rsp_data <= pipe_res_data;
      end
    end
  end

endmodule

// File: tb/tb_crypto_pipe_sched.sv
// Self-checking bench for crypto_pipe_sched: directed scenarios plus random
// traffic, compared each cycle against a behavioural scheduler model.
module tb_crypto_pipe_sched;

  localparam int NR  = 4;
  localparam int LAT = 4;
  localparam int IDW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*16-1:0]  req_data;
  logic [NR*6-1:0]   req_key;
  logic              pipe_valid;
  logic [15:0]       pipe_data;
  logic [5:0]        pipe_key;
  logic [15:0]       pipe_res_data;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [15:0]       rsp_data;
  logic              busy;

  crypto_pipe_sched #(.NUM_REQ(NR), .PIPE_LAT(LAT), .ID_W(IDW)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_data      (req_data),
    .req_key       (req_key),
    .pipe_valid    (pipe_valid),
    .pipe_data     (pipe_data),
    .pipe_key      (pipe_key),
    .pipe_res_data (pipe_res_data),
    .rsp_valid     (rsp_valid),
    .rsp_id        (rsp_id),
    .rsp_data      (rsp_data),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int mode  = 0;

  // client request state
  bit          cv [NR];
  logic [15:0] cd [NR];
  logic [5:0]  ck [NR];

  // reference model
  typedef struct { int due; int id; } rsp_t;
  rsp_t        rsp_q [$];
  int          issue_q [$];
  logic [15:0] res_hist [0:8191];
  int          m_ptr, m_pend;
  logic [5:0]  m_key;
  bit          m_drain, m_nonidle;
  bit          exp_pv;
  logic [15:0] exp_pdata;
  logic [5:0]  exp_pkey;

  // scenario trackers
  bit track_blk = 1'b0;
  int blk2 = 0;
  int wait3 = 0;
  int maxwait3 = 0;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    rsp_q.delete();
    issue_q.delete();
    m_ptr = 0; m_pend = -1; m_key = 6'h00;
    m_drain = 1'b0; m_nonidle = 1'b0;
    exp_pv = 1'b0; exp_pdata = 16'h0000; exp_pkey = 6'h00;
  endtask

  task automatic raise(input int i, input logic [15:0] d, input logic [5:0] k);
    cv[i] = 1'b1; cd[i] = d; ck[i] = k;
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]       = cv[i];
      req_data[16*i +: 16] = cd[i];
      req_key[6*i +: 6]    = ck[i];
    end
    pipe_res_data = 16'($urandom);
  endtask

  task automatic gen();
    int r;
    for (int i = 0; i < NR; i++) begin
      if (mode == 1 && !cv[i] && $urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 7);
        raise(i, 16'($urandom), (r < 5) ? 6'h05 : ((r < 7) ? 6'h11 : 6'h2A));
      end else if (mode == 2 && !cv[i]) begin
        raise(i, 16'($urandom), 6'h05);
      end
    end
  endtask

  task automatic eval_cycle();
    int w, g, infl;
    bit drain_nxt;
    logic [NR-1:0] exp_rdy, hs;
    while (issue_q.size() > 0 && issue_q[0] + LAT < cyc) void'(issue_q.pop_front());
    infl = 0;
    foreach (issue_q[k]) if (issue_q[k] + 1 <= cyc && cyc <= issue_q[k] + LAT) infl++;
    w = -1; g = -1; drain_nxt = m_drain;
    if (m_drain) begin
      if (infl == 0) drain_nxt = 1'b0;
    end else begin
      if (m_pend >= 0) w = m_pend;
      else for (int k = 0; k < NR; k++) begin
        int j;
        j = (m_ptr + k) % NR;
        if (w < 0 && cv[j]) w = j;
      end
      if (w >= 0) begin
        if (ck[w] == m_key || infl == 0) g = w;
        else begin drain_nxt = 1'b1; m_pend = w; end
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk_eq("pipe_valid", 32'(pipe_valid), 32'(exp_pv));
    chk_eq("pipe_data", 32'(pipe_data), 32'(exp_pdata));
    chk_eq("pipe_key", 32'(pipe_key), 32'(exp_pkey));
    chk_eq("busy", 32'(busy), 32'(m_nonidle || infl > 0));
    if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      chk_eq("rsp_valid", 32'(rsp_valid), 32'd1);
      chk_eq("rsp_id", 32'(rsp_id), 32'(rsp_q[0].id));
      chk_eq("rsp_data", 32'(rsp_data), 32'(res_hist[cyc-1]));
      void'(rsp_q.pop_front());
    end else begin
      chk_eq("rsp_idle", 32'(rsp_valid), 32'd0);
    end
    res_hist[cyc] = pipe_res_data;
    exp_pv = (g >= 0);
    if (g >= 0) begin
      exp_pdata = cd[g]; exp_pkey = ck[g]; m_key = ck[g];
      m_ptr = (g + 1) % NR; m_pend = -1;
      issue_q.push_back(cyc);
      rsp_q.push_back('{due: cyc + LAT + 2, id: g});
    end
    m_nonidle = m_drain || (w >= 0);
    m_drain = drain_nxt;
    if (track_blk && cv[2] && !req_ready[2]) blk2++;
    if (mode == 2 && cv[3]) begin
      wait3++;
      if (req_ready[3]) begin
        if (wait3 > maxwait3) maxwait3 = wait3;
        wait3 = 0;
      end
    end
    hs = req_valid & req_ready;
    for (int i = 0; i < NR; i++) if (hs[i]) cv[i] = 1'b0;
  endtask

  task automatic cycle_step();
    @(posedge clk); cyc++;
    #1; gen(); drive();
    @(negedge clk);
    eval_cycle();
  endtask

  task automatic do_reset();
    @(posedge clk); cyc++;
    #1; rst = 1'b1;
    for (int i = 0; i < NR; i++) cv[i] = 1'b0;
    drive();
    #1;
    chk_eq("rst_req_ready", 32'(req_ready), 32'd0);
    chk_eq("rst_pipe_valid", 32'(pipe_valid), 32'd0);
    chk_eq("rst_pipe_data", 32'(pipe_data), 32'd0);
    chk_eq("rst_pipe_key", 32'(pipe_key), 32'd0);
    chk_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk_eq("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk_eq("rst_busy", 32'(busy), 32'd0);
    repeat (2) begin @(posedge clk); cyc++; end
    #1; rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < NR; i++) begin cv[i] = 1'b0; cd[i] = 16'h0; ck[i] = 6'h0; end
    drive();
    model_reset();
    do_reset();

    // all four clients, same key, pointer 0: grants 0,1,2,3 back to back
    mode = 0;
    for (int i = 0; i < NR; i++) raise(i, 16'hA000 + 16'(i), 6'h05);
    repeat (12) cycle_step();

    // single client, new key on an empty pipe
    raise(0, 16'h1234, 6'h2A);
    repeat (10) cycle_step();

    // key change behind an in-flight word forces a drain
    raise(1, 16'h0BEE, 6'h05);
    cycle_step();
    raise(2, 16'h0C0D, 6'h11);
    track_blk = 1'b1; blk2 = 0;
    repeat (12) cycle_step();
    track_blk = 1'b0;
    chk_eq("drain_block_cycles", 32'(blk2), 32'(LAT + 1));

    // saturation: client 3 must not starve
    mode = 2; wait3 = 0; maxwait3 = 0;
    repeat (40) cycle_step();
    mode = 0;
    repeat (12) cycle_step();
    chk_eq("no_starve", 32'(maxwait3 >= 1 && maxwait3 <= NR), 32'd1);

    // random traffic, then a long quiet period
    mode = 1;
    repeat (400) cycle_step();
    mode = 0;
    repeat (40) cycle_step();
    chk_eq("quiet_busy", 32'(busy), 32'd0);
    chk_eq("quiet_pipe_valid", 32'(pipe_valid), 32'd0);
    chk_eq("quiet_pipe_key", 32'(pipe_key), 32'(m_key));

    // reset two cycles after three issues discards their tags
    raise(0, 16'h1111, 6'h05);
    raise(1, 16'h2222, 6'h05);
    raise(2, 16'h3333, 6'h05);
    repeat (3) cycle_step();
    repeat (2) cycle_step();
    do_reset();
    repeat (15) cycle_step();
    chk_eq("post_rst_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
